y86_fetch: RTL and testbench
============================

Name: y86_fetch

Overview:
- Fetch stage: the producer of the instruction fields that the decode/register-file stage consumes (icode, ifun, rA, rB, valC, valP).
- Holds a byte-addressed instruction memory, loaded through a byte-write port before execution.
- Holds the PC and splits the variable-length Y86-64 encoding into fields.
- Hands each instruction downstream over a valid/ready handshake; a PC redirect input from execute/memory handles taken jumps, call and ret.

Parameters:
- IMEM_BYTES, 1024, instruction memory size in bytes.
- ADDR_W, 10, load-port address width; must satisfy 2**ADDR_W >= IMEM_BYTES.
- RESET_PC, 64'd0, PC value after reset and on start.

Ports:
- clk  input  1  clock; all state changes on posedge.
- rst  input  1  asynchronous, active-high reset.
- load_en  input  1  write one byte to imem; honoured only in IDLE.
- load_addr  input  ADDR_W  byte address for the load.
- load_data  input  8  byte to write.
- start  input  1  leave IDLE and begin fetching at RESET_PC.
- redir_valid  input  1  PC redirect request.
- redir_pc  input  64  redirect target.
- f_ready  input  1  decode accepts the current instruction.
- f_valid  output  1  fields below are valid.
- icode  output  4  instruction code.
- ifun  output  4  function code.
- rA  output  4  register A; 4'hF when the instruction has no register byte.
- rB  output  4  register B; 4'hF when the instruction has no register byte.
- valC  output  64  constant word, little-endian; 0 if none.
- valP  output  64  pc + instruction length.
- pc  output  64  current PC.
- stat  output  3  1=AOK, 2=HLT, 3=ADR, 4=INS.
- halted  output  1  high in HLT or ERR state.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE, pc=RESET_PC, stat=AOK.
  - f_valid=0, halted=0.
  - Imem contents are not cleared.
- States: IDLE, FETCH, HLT, ERR.
- IDLE:
  - load_en writes imem[load_addr]=load_data at posedge; writes with load_addr >= IMEM_BYTES are ignored.
  - start goes to FETCH with pc=RESET_PC. If start and load_en arrive together, the write completes first.
- FETCH, field extraction:
  - Byte0[7:4]=icode, byte0[3:0]=ifun.
  - Instruction lengths:
    - halt(0), nop(1), ret(9): 1 byte.
    - cmovXX(2), OPq(6), pushq(A), popq(B): 2 bytes.
    - jXX(7), call(8): 9 bytes, valC = bytes1..8.
    - irmovq(3), rmmovq(4), mrmovq(5): 10 bytes, byte1 = {rA,rB}, valC = bytes2..9.
  - Fields are combinational from pc and imem. f_valid=1 only when the fetch is legal.
- FETCH, error checks:
  - icode > 4'hB: stat=INS, go to ERR, f_valid=0.
  - pc+len-1 >= IMEM_BYTES (any byte out of range): stat=ADR, go to ERR, f_valid=0.
  - An out-of-range pc takes ADR priority over the INS check.
- FETCH, PC update on posedge:
  - If redir_valid: pc=redir_pc. Redirect wins over a simultaneous handshake, and the handshaken instruction still counts as delivered.
  - Else if f_valid && f_ready: pc=valP.
  - Else pc holds and all outputs stay stable (stall).
- halt:
  - Presented with f_valid=1 and stat=AOK.
  - On handshake: go to HLT, stat=HLT, f_valid=0.
  - A redirect in the same cycle is ignored.
- HLT / ERR:
  - Terminal; only rst exits.
  - f_valid=0, halted=1, pc frozen; redir, start and load are ignored.
- Reset mid-FETCH aborts immediately; no partial handshake is reported.
- Arithmetic: valP and redir_pc are 64-bit; pc wraps modulo 2^64, and a wrapped pc fails the ADR check.

Decomposition:
- Package y86_pkg holds:
  - icode constants I_HALT..I_POPQ.
  - Stat codes S_AOK, S_HLT, S_ADR, S_INS.
  - Fetch state enum.
  - REG_NONE = 4'hF.
- Sub-module y86_insn_len (combinational), icode -> {instr_valid, need_regids, need_valC, len[3:0]}.

Test Plan:
- Load irmovq $0x123456789ABCDEF0,%rbx (30 F3 F0 DE BC 9A 78 56 34 12) at 0, start, f_ready=1 -> icode=3, rA=F, rB=3, valC=0x123456789ABCDEF0, valP=10, next cycle pc=10.
- Load OPq addq %rax,%rcx (60 01) then halt (00), f_ready held low 3 cycles -> outputs stable, pc=0; then ready -> pc=2, halt delivered, stat=2, halted=1.
- Load jmp 0x20 (70 20 00..00) at 0; assert redir_valid with redir_pc=0x20 on the handshake cycle -> pc=0x20 next cycle, not 9.
- Byte 0xC0 at pc -> f_valid=0, stat=4, halted=1; later redir and start have no effect.
- IMEM_BYTES=16, irmovq placed at 10 (ends at 19) -> stat=3, ERR.
- Assert rst mid-FETCH, asynchronously between edges -> pc=RESET_PC, f_valid=0, state IDLE immediately; imem preserved, so start re-runs the program identically.

Source files
------------

// File: rtl/y86_pkg.sv
// Shared definitions for the Y86-64 fetch stage.
//   - icode constants (I_HALT .. I_POPQ)
//   - status codes reported on the stat output
//   - fetch controller state encoding
//   - REG_NONE: register id driven when an instruction has no register byte
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [2:0] S_AOK = 3'd1;
    localparam logic [2:0] S_HLT = 3'd2;
    localparam logic [2:0] S_ADR = 3'd3;
    localparam logic [2:0] S_INS = 3'd4;

    localparam logic [3:0] REG_NONE = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HLT   = 2'd2,
        ST_ERR   = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/y86_insn_len.sv
// Instruction shape decoder (purely combinational).
// Ports:
//   icode        in   4  instruction code from byte 0
//   instr_valid  out  1  icode is a defined Y86-64 instruction
//   need_regids  out  1  byte 1 carries {rA, rB}
//   need_valC    out  1  an 8-byte little-endian constant follows
//   len          out  4  total instruction length in bytes
module y86_insn_len
    import y86_pkg::*;
(
    input  logic [3:0] icode,
    output logic       instr_valid,
    output logic       need_regids,
    output logic       need_valC,
    output logic [3:0] len
);

    always_comb begin
        instr_valid = 1'b1;
        need_regids = 1'b0;
        need_valC   = 1'b0;
        len         = 4'd1;
        case (icode)
            I_HALT, I_NOP, I_RET: begin
                len = 4'd1;
            end
            I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: begin
                need_regids = 1'b1;
                len         = 4'd2;
            end
            I_JXX, I_CALL: begin
                need_valC = 1'b1;
                len       = 4'd9;
            end
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: begin
                need_regids = 1'b1;
                need_valC   = 1'b1;
                len         = 4'd10;
            end
            default: begin
                // Undefined opcode: length 1 keeps the range check confined
                // to byte 0 so an in-range bad opcode reports INS, not ADR.
                instr_valid = 1'b0;
                len         = 4'd1;
            end
        endcase
    end

endmodule

// File: rtl/y86_fetch.sv
// Y86-64 fetch stage with a byte-addressed instruction memory.
// The memory is filled through the load port while IDLE; start then fetches
// from RESET_PC and presents decoded fields over a valid/ready handshake.
// Ports:
//   clk, rst                      clock, async active-high reset
//   load_en/load_addr/load_data   byte write into imem (IDLE only)
//   start                         IDLE -> FETCH at RESET_PC
//   redir_valid/redir_pc          PC redirect from execute/memory
//   f_ready                       downstream accepts the current instruction
//   f_valid                       decoded fields below are valid
//   icode, ifun, rA, rB, valC     instruction fields
//   valP                          pc + instruction length
//   pc                            current PC
//   stat                          1=AOK 2=HLT 3=ADR 4=INS
//   halted                        in HLT or ERR
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | imem loadable, waiting for start
// ST_FETCH | decoding imem at pc, handing instructions downstream
// ST_HLT   | halt delivered; frozen until reset
// ST_ERR   | address or opcode fault; frozen until reset
module y86_fetch
    import y86_pkg::*;
#(
    parameter int          IMEM_BYTES = 1024,
    parameter int          ADDR_W     = 10,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [7:0]        load_data,
    input  logic              start,
    input  logic              redir_valid,
    input  logic [63:0]       redir_pc,
    input  logic              f_ready,
    output logic              f_valid,
    output logic [3:0]        icode,
    output logic [3:0]        ifun,
    output logic [3:0]        rA,
    output logic [3:0]        rB,
    output logic [63:0]       valC,
    output logic [63:0]       valP,
    output logic [63:0]       pc,
    output logic [2:0]        stat,
    output logic              halted
);

    localparam int          IDX_W     = (IMEM_BYTES > 1) ? $clog2(IMEM_BYTES) : 1;
    localparam logic [63:0] IMEM_SIZE = 64'(IMEM_BYTES);
    localparam logic [ADDR_W:0] LOAD_LIM = (ADDR_W + 1)'(IMEM_BYTES);

    fetch_state_t state, next_state;
    logic [63:0]  next_pc;
    logic [2:0]   next_stat;

    logic [7:0]   imem [IMEM_BYTES];
    logic [7:0]   ib   [10];
    logic [63:0]  baddr;

    logic         instr_valid;
    logic         need_regids;
    logic         need_valC;
    logic [3:0]   len;

    logic [63:0]  end_addr;
    logic         pc_oob;
    logic         err_adr;
    logic         err_ins;
    logic         handshake;

    // Instruction memory: no reset so a program survives rst.
    always_ff @(posedge clk) begin
        if (state == ST_IDLE && load_en && ({1'b0, load_addr} < LOAD_LIM)) begin
            imem[load_addr[IDX_W-1:0]] <= load_data;
        end
    end

    // Read the ten bytes an instruction can span; bytes past the end read 0
    // and are caught by the range check below.
    always_comb begin
        baddr = '0;
        for (int i = 0; i < 10; i++) begin
            baddr = pc + 64'(i);
            ib[i] = 8'h00;
            if (baddr < IMEM_SIZE) begin
                ib[i] = imem[baddr[IDX_W-1:0]];
            end
        end
    end

    assign icode = ib[0][7:4];
    assign ifun  = ib[0][3:0];

    y86_insn_len u_insn_len (
        .icode       (icode),
        .instr_valid (instr_valid),
        .need_regids (need_regids),
        .need_valC   (need_valC),
        .len         (len)
    );

    assign rA = need_regids ? ib[1][7:4] : REG_NONE;
    assign rB = need_regids ? ib[1][3:0] : REG_NONE;

    always_comb begin
        valC = 64'd0;
        if (need_valC) begin
            if (need_regids) begin
                valC = {ib[9], ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2]};
            end else begin
                valC = {ib[8], ib[7], ib[6], ib[5], ib[4], ib[3], ib[2], ib[1]};
            end
        end
    end

    assign valP     = pc + 64'(len);
    assign end_addr = valP - 64'd1;

    // An out-of-range pc is ADR regardless of what byte 0 decodes to; the
    // end < pc term catches a span that wraps past 2^64.
    assign pc_oob  = (pc >= IMEM_SIZE);
    assign err_adr = pc_oob || (instr_valid && ((end_addr >= IMEM_SIZE) || (end_addr < pc)));
    assign err_ins = !pc_oob && !instr_valid;

    assign f_valid   = (state == ST_FETCH) && !err_adr && !err_ins;
    assign handshake = f_valid && f_ready;
    assign halted    = (state == ST_HLT) || (state == ST_ERR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pc    <= RESET_PC;
            stat  <= S_AOK;
        end else begin
            state <= next_state;
            pc    <= next_pc;
            stat  <= next_stat;
        end
    end

    always_comb begin
        next_state = state;
        next_pc    = pc;
        next_stat  = stat;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_FETCH;
                    next_pc    = RESET_PC;
                    next_stat  = S_AOK;
                end
            end
            ST_FETCH: begin
                if (err_adr) begin
                    next_state = ST_ERR;
                    next_stat  = S_ADR;
                end else if (err_ins) begin
                    next_state = ST_ERR;
                    next_stat  = S_INS;
                end else if (handshake && icode == I_HALT) begin
                    // pc stays on the halt; a concurrent redirect is dropped.
                    next_state = ST_HLT;
                    next_stat  = S_HLT;
                end else if (redir_valid) begin
                    next_pc = redir_pc;
                end else if (handshake) begin
                    next_pc = valP;
                end
            end
            ST_HLT, ST_ERR: begin
                next_state = state;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_y86_fetch.sv
module tb_y86_fetch;

    logic        clk;
    logic        rst;
    logic        load_en;
    logic [4:0]  load_addr;
    logic [7:0]  load_data;
    logic        start;
    logic        redir_valid;
    logic [63:0] redir_pc;
    logic        f_ready;
    logic        f_valid;
    logic [3:0]  icode, ifun, rA, rB;
    logic [63:0] valC, valP, pc;
    logic [2:0]  stat;
    logic        halted;

    int checks   = 0;
    int failures = 0;

    y86_fetch #(
        .IMEM_BYTES (16),
        .ADDR_W     (5),
        .RESET_PC   (64'd0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load_en     (load_en),
        .load_addr   (load_addr),
        .load_data   (load_data),
        .start       (start),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .f_ready     (f_ready),
        .f_valid     (f_valid),
        .icode       (icode),
        .ifun        (ifun),
        .rA          (rA),
        .rB          (rB),
        .valC        (valC),
        .valP        (valP),
        .pc          (pc),
        .stat        (stat),
        .halted      (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [79:0] bytes;
        int          n;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [63:0] valc;
        logic [63:0] valp;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst         = 1'b1;
        load_en     = 1'b0;
        load_addr   = '0;
        load_data   = '0;
        start       = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = '0;
        f_ready     = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic load_byte(input logic [4:0] a, input logic [7:0] d);
        load_en   = 1'b1;
        load_addr = a;
        load_data = d;
        tick();
        load_en = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 16; i++) load_byte(5'(i), 8'h00);
    endtask

    task automatic load_prog(input logic [79:0] b, input int n, input int base);
        for (int i = 0; i < n; i++) load_byte(5'(base + i), b[i*8 +: 8]);
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        vecs[0] = '{"irmovq", 80'h123456789ABCDEF0_F3_30, 10, 4'h3, 4'h0, 4'hF, 4'h3, 64'h123456789ABCDEF0, 64'd10};
        vecs[1] = '{"addq",   80'h0160,                    2, 4'h6, 4'h0, 4'h0, 4'h1, 64'd0,              64'd2};
        vecs[2] = '{"jmp",    80'h00_0000000000000020_70,  9, 4'h7, 4'h0, 4'hF, 4'hF, 64'h20,             64'd9};
        vecs[3] = '{"call",   80'h00_0102030405060708_80,  9, 4'h8, 4'h0, 4'hF, 4'hF, 64'h0102030405060708, 64'd9};
        vecs[4] = '{"ret",    80'h90,                      1, 4'h9, 4'h0, 4'hF, 4'hF, 64'd0,              64'd1};
        vecs[5] = '{"rmmovq", 80'h0000000000000008_62_40, 10, 4'h4, 4'h0, 4'h6, 4'h2, 64'h8,              64'd10};
        vecs[6] = '{"pushq",  80'h5FA0,                    2, 4'hA, 4'h0, 4'h5, 4'hF, 64'd0,              64'd2};
        vecs[7] = '{"cmovle", 80'h2321,                    2, 4'h2, 4'h1, 4'h2, 4'h3, 64'd0,              64'd2};
        vecs[8] = '{"mrmovq", 80'hFFFFFFFFFFFFFFFF_17_50, 10, 4'h5, 4'h0, 4'h1, 4'h7, 64'hFFFFFFFFFFFFFFFF, 64'd10};
        vecs[9] = '{"popq",   80'h7FB0,                    2, 4'hB, 4'h0, 4'h7, 4'hF, 64'd0,              64'd2};

        do_reset();
        check("reset_pc", pc, 64'd0);
        check("reset_stat", 64'(stat), 64'd1);
        check("reset_fvalid", 64'(f_valid), 64'd0);
        check("reset_halted", 64'(halted), 64'd0);

        // Field decode table; the out-of-range write to address 16 must not
        // alias onto byte 0.
        foreach (vecs[k]) begin
            do_reset();
            clear_mem();
            load_prog(vecs[k].bytes, vecs[k].n, 0);
            load_byte(5'd16, 8'hC0);
            do_start();
            check({vecs[k].name, "_fvalid"}, 64'(f_valid), 64'd1);
            check({vecs[k].name, "_icode"},  64'(icode),  64'(vecs[k].icode));
            check({vecs[k].name, "_ifun"},   64'(ifun),   64'(vecs[k].ifun));
            check({vecs[k].name, "_rA"},     64'(rA),     64'(vecs[k].ra));
            check({vecs[k].name, "_rB"},     64'(rB),     64'(vecs[k].rb));
            check({vecs[k].name, "_valC"},   valC,        vecs[k].valc);
            check({vecs[k].name, "_valP"},   valP,        vecs[k].valp);
        end

        // irmovq handshake advances to valP, then the trailing halt.
        do_reset();
        clear_mem();
        load_prog(vecs[0].bytes, 10, 0);
        do_start();
        f_ready = 1'b1;
        tick();
        check("irmovq_next_pc", pc, 64'd10);
        check("irmovq_next_halt_valid", 64'(f_valid), 64'd1);
        tick();
        f_ready = 1'b0;
        check("irmovq_halt_stat", 64'(stat), 64'd2);
        check("irmovq_halted", 64'(halted), 64'd1);

        // Stall: addq held three cycles, then halt.
        do_reset();
        clear_mem();
        load_prog(80'h00_01_60, 3, 0);
        do_start();
        for (int c = 0; c < 3; c++) begin
            tick();
            check("stall_pc", pc, 64'd0);
            check("stall_icode", 64'(icode), 64'h6);
            check("stall_valP", valP, 64'd2);
            check("stall_fvalid", 64'(f_valid), 64'd1);
        end
        f_ready = 1'b1;
        tick();
        check("addq_pc", pc, 64'd2);
        check("halt_icode", 64'(icode), 64'h0);
        check("halt_fvalid", 64'(f_valid), 64'd1);
        check("halt_pre_stat", 64'(stat), 64'd1);
        tick();
        f_ready = 1'b0;
        check("halt_stat", 64'(stat), 64'd2);
        check("halt_halted", 64'(halted), 64'd1);
        check("halt_fvalid_off", 64'(f_valid), 64'd0);
        check("halt_pc_frozen", pc, 64'd2);

        // Redirect coinciding with a halt handshake is dropped.
        do_reset();
        clear_mem();
        do_start();
        f_ready     = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 64'd5;
        tick();
        redir_valid = 1'b0;
        f_ready     = 1'b0;
        check("halt_redir_stat", 64'(stat), 64'd2);
        check("halt_redir_pc", pc, 64'd0);

        // jmp with redirect on the handshake cycle: target wins over valP.
        do_reset();
        clear_mem();
        load_prog(vecs[2].bytes, 9, 0);
        do_start();
        f_ready     = 1'b1;
        redir_valid = 1'b1;
        redir_pc    = 64'h20;
        tick();
        redir_valid = 1'b0;
        f_ready     = 1'b0;
        check("jmp_redir_pc", pc, 64'h20);
        check("jmp_oob_fvalid", 64'(f_valid), 64'd0);
        tick();
        check("jmp_oob_stat", 64'(stat), 64'd3);
        check("jmp_oob_halted", 64'(halted), 64'd1);

        // Illegal opcode, then everything but reset is ignored.
        do_reset();
        clear_mem();
        load_byte(5'd0, 8'hC0);
        do_start();
        check("ins_fvalid", 64'(f_valid), 64'd0);
        tick();
        check("ins_stat", 64'(stat), 64'd4);
        check("ins_halted", 64'(halted), 64'd1);
        redir_valid = 1'b1;
        redir_pc    = 64'd2;
        start       = 1'b1;
        load_en     = 1'b1;
        load_addr   = 5'd0;
        load_data   = 8'h10;
        repeat (2) tick();
        redir_valid = 1'b0;
        start       = 1'b0;
        load_en     = 1'b0;
        check("ins_stat_held", 64'(stat), 64'd4);
        check("ins_pc_held", pc, 64'd0);
        check("ins_fvalid_held", 64'(f_valid), 64'd0);
        do_reset();
        do_start();
        check("ins_load_ignored", 64'(icode), 64'hC);

        // irmovq at 10 spans 10..19 in a 16-byte memory.
        do_reset();
        clear_mem();
        load_byte(5'd0, 8'h10);
        load_prog(80'h9ABCDEF0_F3_30, 6, 10);
        do_start();
        redir_valid = 1'b1;
        redir_pc    = 64'd10;
        tick();
        redir_valid = 1'b0;
        check("adr_span_pc", pc, 64'd10);
        check("adr_span_icode", 64'(icode), 64'h3);
        check("adr_span_fvalid", 64'(f_valid), 64'd0);
        tick();
        check("adr_span_stat", 64'(stat), 64'd3);

        // pc near 2^64 reports ADR.
        do_reset();
        clear_mem();
        do_start();
        redir_valid = 1'b1;
        redir_pc    = 64'hFFFF_FFFF_FFFF_FFFF;
        tick();
        redir_valid = 1'b0;
        check("wrap_fvalid", 64'(f_valid), 64'd0);
        tick();
        check("wrap_stat", 64'(stat), 64'd3);

        // Async reset between edges mid-FETCH, then the program reruns.
        do_reset();
        clear_mem();
        load_prog(80'h00_10_01_60, 4, 0);
        do_start();
        f_ready = 1'b1;
        tick();
        check("mid_pc", pc, 64'd2);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_pc", pc, 64'd0);
        check("async_rst_fvalid", 64'(f_valid), 64'd0);
        check("async_rst_halted", 64'(halted), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_start();
        check("rerun_pc0", pc, 64'd0);
        check("rerun_icode0", 64'(icode), 64'h6);
        tick();
        check("rerun_pc2", pc, 64'd2);
        check("rerun_icode1", 64'(icode), 64'h1);
        tick();
        check("rerun_pc3", pc, 64'd3);
        check("rerun_halt_valid", 64'(f_valid), 64'd1);
        tick();
        f_ready = 1'b0;
        check("rerun_stat", 64'(stat), 64'd2);
        check("rerun_halted", 64'(halted), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
